// File: rtl/apb_spi_xip_ctrl.sv
// apb_spi_xip_ctrl: APB execute-in-place read bridge to SPI NOR flash plus CSR window
// Optional feature: define SPI_XIP_FAST_READ_EN for fast-read (0x0B) with 8 dummy SCK periods.
module apb_spi_xip_ctrl #(
    parameter logic [31:0] FLASH_ADDR_START = 32'h3000_0000,
    parameter logic [31:0] FLASH_ADDR_END   = 32'h3fff_ffff,
    parameter logic [31:0] CSR_BASE         = 32'h1000_1000,
    parameter logic [31:0] CSR_END          = 32'h1000_1fff,
    parameter int          SS_NUM           = 8,
    parameter int          FLASH_SS_IDX     = 0,
    parameter logic [15:0] DIV_RESET        = 16'd1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [31:0]       in_paddr,
    input  logic              in_psel,
    input  logic              in_penable,
    input  logic [2:0]        in_pprot,
    input  logic              in_pwrite,
    input  logic [31:0]       in_pwdata,
    input  logic [3:0]        in_pstrb,
    output logic              in_pready,
    output logic [31:0]       in_prdata,
    output logic              in_pslverr,
    output logic              spi_sck,
    output logic [SS_NUM-1:0] spi_ss,
    output logic              spi_mosi,
    input  logic              spi_miso
);
`ifdef SPI_XIP_FAST_READ_EN
    localparam logic [7:0] CMD_BYTE = 8'h0B;
`else
    localparam logic [7:0] CMD_BYTE = 8'h03;
`endif
    typedef enum logic [2:0] {
        IDLE,
        CMD,
`ifdef SPI_XIP_FAST_READ_EN
        DUMMY,
`endif
        DATA,
        DONE
    } state_t;
    state_t state, state_nxt;
    logic [15:0] div, d, cnt;
    logic [31:0] xfer_cnt, tx, rx, csr_rdata;
    logic [4:0] bits;
    logic sck, ss_act, last_err;
    logic acc, in_xip, in_csr, xip_rd, flash_rd, flash_wr, csr_wr, shifting, tick, rise, fall, phase_end;
    logic unused_bits;

    assign unused_bits = ^{in_pprot, in_pwdata[31:16], in_pstrb[3:2]};
    assign acc = in_psel & in_penable;
    assign in_xip = (in_paddr >= FLASH_ADDR_START) && (in_paddr <= FLASH_ADDR_END);
    assign in_csr = (in_paddr >= CSR_BASE) && (in_paddr <= CSR_END);
    assign xip_rd = in_xip & ~in_pwrite;
    assign flash_rd = acc & xip_rd;
    assign flash_wr = acc & in_xip & in_pwrite;
    assign csr_wr = acc & in_csr & in_pwrite;
    assign shifting = (state != IDLE) && (state != DONE);
    assign tick = shifting && (cnt == d);
    assign rise = tick & ~sck;
    assign fall = tick & sck;
    // every phase ends on the falling edge of its bit 31 (dummy phase starts counting at 24)
    assign phase_end = fall && (bits == 5'd31);
    assign spi_sck = sck;
    assign spi_mosi = tx[31];
    assign spi_ss = ~(SS_NUM'(ss_act) << FLASH_SS_IDX);

    // state register
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // next state and APB response
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = flash_rd ? CMD : IDLE;
`ifdef SPI_XIP_FAST_READ_EN
            CMD:     state_nxt = phase_end ? DUMMY : CMD;
            DUMMY:   state_nxt = phase_end ? DATA : DUMMY;
`else
            CMD:     state_nxt = phase_end ? DATA : CMD;
`endif
            DATA:    state_nxt = phase_end ? DONE : DATA;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        csr_rdata = (in_paddr[3:2] == 2'd0) ? {16'd0, div} :
                    (in_paddr[3:2] == 2'd1) ? {30'd0, last_err, state != IDLE} :
                    (in_paddr[3:2] == 2'd2) ? xfer_cnt : 32'd0;
        in_pready = (state == DONE) | (acc & ~xip_rd);
        in_pslverr = acc & ~xip_rd & ~in_csr;
        in_prdata = (state == DONE) ? {rx[7:0], rx[15:8], rx[23:16], rx[31:24]} :
                    (acc & in_csr & ~in_pwrite) ? csr_rdata : 32'd0;
    end

    // CSR registers: divider, transfer counter, last flash error flag
    always_ff @(posedge clock) begin
        if (reset) begin
            div <= DIV_RESET;
            xfer_cnt <= 32'd0;
            last_err <= 1'b0;
        end else begin
            if (csr_wr && in_paddr[3:2] == 2'd0 && in_pstrb[0]) div[7:0] <= in_pwdata[7:0];
            if (csr_wr && in_paddr[3:2] == 2'd0 && in_pstrb[1]) div[15:8] <= in_pwdata[15:8];
            if (state == DONE) xfer_cnt <= xfer_cnt + 32'd1;
            else if (csr_wr && in_paddr[3:2] == 2'd2) xfer_cnt <= 32'd0;
            if (flash_wr) last_err <= 1'b1;
            else if (state == DONE) last_err <= 1'b0;
        end
    end

    // SPI engine: SCK divider, command/address shift-out, data shift-in
    always_ff @(posedge clock) begin
        if (reset) begin
            sck <= 1'b0;
            ss_act <= 1'b0;
            d <= 16'd0;
            cnt <= 16'd0;
            bits <= 5'd0;
            tx <= 32'd0;
            rx <= 32'd0;
        end else if (state == IDLE) begin
            cnt <= 16'd0;
            bits <= 5'd0;
            if (flash_rd) begin
                d <= div;
                tx <= {CMD_BYTE, in_paddr[23:2], 2'b00};
                ss_act <= 1'b1;
            end
        end else if (shifting) begin
            cnt <= tick ? 16'd0 : cnt + 16'd1;
            if (tick) sck <= ~sck;
            if (rise && state == DATA) rx <= {rx[30:0], spi_miso};
            if (fall) begin
                tx <= {tx[30:0], 1'b0};
`ifdef SPI_XIP_FAST_READ_EN
                bits <= (state == CMD && phase_end) ? 5'd24 : bits + 5'd1;
`else
                bits <= bits + 5'd1;
`endif
                if (state == DATA && phase_end) ss_act <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_apb_spi_xip_ctrl.sv
// tb_apb_spi_xip_ctrl: randomized APB/SPI bench with behavioural flash and CSR reference model
module tb_apb_spi_xip_ctrl;
`ifdef SPI_XIP_FAST_READ_EN
    localparam int NHALF = 144;
    localparam logic [7:0] CMD_BYTE = 8'h0B;
`else
    localparam int NHALF = 128;
    localparam logic [7:0] CMD_BYTE = 8'h03;
`endif
    localparam int NPRE = NHALF / 2 - 32;
    logic clock, reset;
    logic [31:0] in_paddr, in_pwdata, in_prdata;
    logic in_psel, in_penable, in_pwrite, in_pready, in_pslverr;
    logic [2:0] in_pprot;
    logic [3:0] in_pstrb;
    logic spi_sck, spi_mosi;
    logic spi_miso = 1'b0;
    logic [7:0] spi_ss;
    int n_checks = 0;
    int n_pass = 0;
    logic [15:0] div_m;
    logic [31:0] xfer_m;
    logic err_m;
    logic prev_sck = 1'b0;
    logic prev_ss = 1'b1;
    logic [31:0] cmd_cap = 32'd0;
    logic [31:0] stream = 32'd0;
    int hp = 0, hp_min = 0, hp_max = 0, rises = 0, falls = 0, dummy_bad = 0, sck_edges = 0, bad_ss = 0;

    apb_spi_xip_ctrl dut (
        .clock(clock), .reset(reset), .in_paddr(in_paddr), .in_psel(in_psel),
        .in_penable(in_penable), .in_pprot(in_pprot), .in_pwrite(in_pwrite),
        .in_pwdata(in_pwdata), .in_pstrb(in_pstrb), .in_pready(in_pready),
        .in_prdata(in_prdata), .in_pslverr(in_pslverr), .spi_sck(spi_sck),
        .spi_ss(spi_ss), .spi_mosi(spi_mosi), .spi_miso(spi_miso)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [7:0] fbyte(input logic [23:0] a);
        return (a[23:2] == 22'h40) ? 8'h11 * {6'd0, a[1:0]} + 8'h11 : a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'hA5;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // SPI flash model: watches pins between clock edges, records timing and answers reads
    always @(negedge clock) begin
        if (!reset && spi_ss !== 8'hFF && spi_ss !== 8'hFE) bad_ss++;
        if (spi_sck !== prev_sck) sck_edges++;
        if (spi_ss[0] === 1'b0) begin
            if (prev_ss) begin
                hp = 0; hp_min = 1 << 30; hp_max = 0; rises = 0; falls = 0; dummy_bad = 0;
            end
            if (spi_sck !== prev_sck) begin
                hp_min = (hp < hp_min) ? hp : hp_min;
                hp_max = (hp > hp_max) ? hp : hp_max;
                hp = 1;
                if (spi_sck) begin
                    rises++;
                    if (rises <= 32) cmd_cap = {cmd_cap[30:0], spi_mosi};
                    else if (rises <= NPRE && spi_mosi) dummy_bad++;
                end else begin
                    falls++;
                    if (falls == NPRE)
                        stream = {fbyte(cmd_cap[23:0]), fbyte(cmd_cap[23:0] + 24'd1),
                                  fbyte(cmd_cap[23:0] + 24'd2), fbyte(cmd_cap[23:0] + 24'd3)};
                    if (falls >= NPRE) begin
                        spi_miso = stream[31];
                        stream = {stream[30:0], 1'b0};
                    end
                end
            end else begin
                hp++;
            end
        end
        prev_sck = spi_sck;
        prev_ss = spi_ss[0];
    end

    task automatic apb(input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
                       input logic [3:0] strb, output logic [31:0] rdata, output logic err, output int lat);
        @(negedge clock);
        in_paddr = addr; in_pwrite = wr; in_pwdata = wdata; in_pstrb = strb;
        in_psel = 1'b1; in_penable = 1'b0;
        @(negedge clock);
        in_penable = 1'b1;
        #1;
        lat = 1;
        while (!in_pready && lat < 5000) begin
            @(negedge clock);
            #1;
            lat++;
        end
        rdata = in_prdata;
        err = in_pslverr;
        @(posedge clock);
        #1;
        in_psel = 1'b0; in_penable = 1'b0;
    endtask

    task automatic csr_all(input string tag);
        logic [31:0] rd;
        logic err;
        int lat;
        apb(32'h1000_1000, 1'b0, 32'd0, 4'd0, rd, err, lat);
        check({tag, "_div"}, rd, {16'd0, div_m});
        apb(32'h1000_1004, 1'b0, 32'd0, 4'd0, rd, err, lat);
        check({tag, "_status"}, rd, {30'd0, err_m, 1'b0});
        apb(32'h1000_1008, 1'b0, 32'd0, 4'd0, rd, err, lat);
        check({tag, "_xfer"}, rd, xfer_m);
        check({tag, "_csr_resp"}, {err, 31'(lat)}, 32'd1);
    endtask

    task automatic csr_write(input string tag, input logic [31:0] addr, input logic [31:0] w, input logic [3:0] strb);
        logic [31:0] rd;
        logic err;
        int lat;
        apb(addr, 1'b1, w, strb, rd, err, lat);
        check({tag, "_wresp"}, {err, 31'(lat)}, 32'd1);
        if (addr[3:2] == 2'd0 && strb[0]) div_m[7:0] = w[7:0];
        if (addr[3:2] == 2'd0 && strb[1]) div_m[15:8] = w[15:8];
        if (addr[3:2] == 2'd2) xfer_m = 32'd0;
    endtask

    task automatic flash_read(input string tag, input logic [31:0] addr, output logic [31:0] rd);
        logic err;
        int lat;
        logic [23:0] a;
        a = {addr[23:2], 2'b00};
        apb(addr, 1'b0, 32'd0, 4'd0, rd, err, lat);
        check({tag, "_data"}, rd, {fbyte(a + 24'd3), fbyte(a + 24'd2), fbyte(a + 24'd1), fbyte(a)});
        check({tag, "_lat"}, 32'(lat), 32'(NHALF * (int'(div_m) + 1) + 2));
        check({tag, "_err"}, {31'd0, err}, 32'd0);
        check({tag, "_cmd"}, cmd_cap, {CMD_BYTE, a});
        check({tag, "_hp"}, {16'(hp_min), 16'(hp_max)}, {16'(int'(div_m) + 1), 16'(int'(div_m) + 1)});
        check({tag, "_rises"}, 32'(rises), 32'(NHALF / 2));
        check({tag, "_dummy"}, 32'(dummy_bad), 32'd0);
        check({tag, "_idle"}, {23'd0, spi_ss, spi_sck}, {23'd0, 8'hFF, 1'b0});
        xfer_m++;
        err_m = 1'b0;
    endtask

    initial begin
        logic [31:0] rd, w, addr;
        logic err;
        int lat, e0, kind;
        reset = 1'b1; in_psel = 1'b0; in_penable = 1'b0; in_pwrite = 1'b0;
        in_paddr = 32'd0; in_pwdata = 32'd0; in_pstrb = 4'd0; in_pprot = 3'd0;
        div_m = 16'd1; xfer_m = 32'd0; err_m = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("rst_ss", 32'(spi_ss), 32'hFF);
        check("rst_pins", {30'd0, spi_sck, spi_mosi}, 32'd0);
        check("rst_apb", {in_pready, in_pslverr, 30'd0}, 32'd0);
        check("rst_prdata", in_prdata, 32'd0);
        @(negedge clock);
        reset = 1'b0;
        csr_all("rst");
        flash_read("rd0", 32'h3000_0102, rd);
        check("rd0_word", rd, 32'h4433_2211);
        csr_all("rd0");
        csr_write("div3", 32'h1000_1000, 32'hABCD_EF03, 4'b0001);
        csr_all("div3");
        flash_read("rd1", 32'h3000_0102, rd);
        check("rd1_word", rd, 32'h4433_2211);
        e0 = sck_edges;
        apb(32'h3000_0000, 1'b1, $urandom, 4'hF, rd, err, lat);
        check("fwr_resp", {err, 31'(lat)}, {1'b1, 31'd1});
        check("fwr_edges", 32'(sck_edges - e0), 32'd0);
        err_m = 1'b1;
        csr_all("fwr");
        apb(32'h2000_0000, 1'b0, 32'd0, 4'd0, rd, err, lat);
        check("unm_resp", {err, 31'(lat)}, {1'b1, 31'd1});
        check("unm_data", rd, 32'd0);
        @(negedge clock);
        in_paddr = 32'h3000_0100; in_pwrite = 1'b0; in_psel = 1'b1; in_penable = 1'b0;
        @(negedge clock);
        in_penable = 1'b1;
        repeat (40) @(negedge clock);
        check("mid_ss", 32'(spi_ss), 32'hFE);
        reset = 1'b1; in_psel = 1'b0; in_penable = 1'b0;
        @(posedge clock);
        #1;
        check("mid_rst_pins", {22'd0, spi_ss, spi_sck, spi_mosi}, {22'd0, 8'hFF, 2'b00});
        check("mid_rst_ready", {31'd0, in_pready}, 32'd0);
        @(negedge clock);
        reset = 1'b0;
        div_m = 16'd1; xfer_m = 32'd0; err_m = 1'b0;
        flash_read("post_rst", 32'h3000_0100, rd);
        check("post_rst_word", rd, 32'h4433_2211);
        csr_all("post_rst");
        for (int i = 0; i < 14; i++) begin
            kind = int'($urandom_range(0, 4));
            if (kind == 0) begin
                w = ($urandom & 32'hFFFF_0000) | 32'($urandom_range(0, 3));
                csr_write("rnd_div", 32'h1000_1000, w, 4'($urandom));
            end else if (kind == 3) begin
                addr = ($urandom & 32'h1) != 0 ? (32'h3000_0000 | ($urandom & 32'h0FFF_FFFF)) : ($urandom & 32'h0FFF_FFFF);
                apb(addr, addr[28], $urandom, 4'hF, rd, err, lat);
                check("rnd_err_resp", {err, 31'(lat)}, {1'b1, 31'd1});
                check("rnd_err_data", rd, 32'd0);
                if (addr[28]) err_m = 1'b1;
            end else if (kind == 4) begin
                csr_write("rnd_status_wr", 32'h1000_1004, $urandom, 4'hF);
            end else begin
                flash_read("rnd_rd", 32'h3000_0000 | ($urandom & 32'h0FFF_FFFF), rd);
            end
            csr_all("rnd");
        end
        csr_write("xclr", 32'h1000_1008, $urandom, 4'($urandom));
        csr_all("xclr");
        check("ss_only_flash", 32'(bad_ss), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/apb_spi_xip_ctrl.md
Name: apb_spi_xip_ctrl

Overview:
- APB slave: execute-in-place (XIP) read bridge to an external SPI NOR flash, plus a small CSR window.
- Drives the SPI pins directly from an internal shifter (SPI mode 0). There is no intermediate bus core and no multi-step register programming per access.
- Successor to the fixed-function flash bridge: configurable address/SS/divider, optional fast-read mode, error responses, and a transfer counter.

Parameters:
- FLASH_ADDR_START, 32'h30000000, first byte address of the XIP window
- FLASH_ADDR_END, 32'h3fffffff, last byte address of the XIP window
- CSR_BASE, 32'h10001000, CSR window base; offsets 0x0/0x4/0x8 decoded from paddr[3:2]
- CSR_END, 32'h10001fff, CSR window end
- SS_NUM, 8, width of spi_ss
- FLASH_SS_IDX, 0, spi_ss bit that selects the flash
- DIV_RESET, 1, reset value of the DIV register

Ports:
- clock  in  1  single clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- in_paddr  in  32  APB address
- in_psel  in  1  APB select
- in_penable  in  1  APB access phase
- in_pprot  in  3  ignored
- in_pwrite  in  1  1 = write
- in_pwdata  in  32  write data
- in_pstrb  in  4  byte strobes
- in_pready  out  1  transfer complete
- in_prdata  out  32  read data
- in_pslverr  out  1  error response, valid with in_pready
- spi_sck  out  1  SPI clock, idles low
- spi_ss  out  SS_NUM  active-low selects
- spi_mosi  out  1  master out
- spi_miso  in  1  master in

Behaviour:
Reset (synchronous, active-high):
- state=IDLE, spi_ss all ones, spi_sck=0, spi_mosi=0.
- in_pready=0, in_pslverr=0, in_prdata=0, DIV=DIV_RESET, XFER_CNT=0.

Access classification (when in_psel & in_penable):
- Flash read: address in XIP window, in_pwrite=0.
- Flash write: pready=1 and pslverr=1 in the same cycle; no SPI activity.
- CSR access: pready=1 combinationally, pslverr=0.
- Unmapped: pready=1, pslverr=1, prdata=0.

CSRs:
- 0x0 DIV: R/W, bits[15:0]; pstrb[0]/[1] gate the bytes; upper bits read 0.
- 0x4 STATUS: RO; bit0 busy, bit1 last flash access errored; writes ignored.
- 0x8 XFER_CNT: RO count of completed flash reads; 32-bit wrap; any write clears it to 0.

Flash read FSM: IDLE -> CMD -> [DUMMY] -> DATA -> DONE -> IDLE.
- IDLE: on a flash read, latch D=DIV and A={in_paddr[23:2],2'b00}. Load shifter with {8'h03, A}. Next cycle assert spi_ss[FLASH_SS_IDX]=0 and present MOSI = shifter bit 31.
- SCK: half period = D+1 clocks. MOSI changes on falling edges; MISO sampled on rising edges. MSB first.
- CMD: 32 SCK periods.
- DATA: 32 SCK periods.
- DONE: single cycle.
  - spi_ss returns all ones and spi_sck=0.
  - in_pready=1 with prdata = bytes in address order, little-endian: first received byte in [7:0], fourth in [31:24].
  - XFER_CNT increments.
- Latency: first access-phase cycle to pready = 128*(D+1)+2 cycles (base mode).
- pready stays 0 during the transfer; CSR accesses cannot occur concurrently because APB is single-master.
- DIV written mid-transfer takes effect on the next read only.
- If psel drops mid-transfer (protocol violation): the transfer still completes; pready is still pulsed in DONE.
- Reset mid-transfer: pins return to reset values on the next edge; no pready.
- D=0xFFFF: half period 65536 clocks; the counter must not overflow.
- Only spi_ss[FLASH_SS_IDX] is ever driven low.

Optional Feature:
SPI_XIP_FAST_READ_EN:
- Defined:
  - Command byte is 8'h0B.
  - DUMMY state inserts 8 SCK periods with MOSI=0 and MISO ignored.
  - Latency becomes 144*(D+1)+2.
- Undefined: command is 8'h03, the DUMMY state is absent, and the latency is as above.

Test Plan:
- Reset -> spi_ss=8'hFF, sck=0, pready=0, DIV reads 1, XFER_CNT reads 0.
- Flash model holds 11 22 33 44 at 0x000100. APB read 0x30000102, DIV=1 -> MOSI 03 00 01 00; prdata=32'h44332211; pready at cycle 258; XFER_CNT=1.
- Write DIV=16'h0003 with pstrb=4'b0001, then read the same flash word -> sck half period 4 clocks; latency 514 cycles; DIV reads 3.
- APB write to 0x30000000 -> pready+pslverr same cycle, no sck edges. Read 0x20000000 -> pslverr=1, prdata=0.
- Assert reset at cycle 40 of a flash read -> next cycle ss=FF, sck=0; a subsequent read completes correctly.
- With SPI_XIP_FAST_READ_EN, read 0x30000100 -> MOSI 0B 00 01 00 then 8 dummy clocks; same prdata; latency 290 at DIV=1.
